gmii_traffic_gen: RTL and testbench
===================================

Name: gmii_traffic_gen

Overview:
- Parametrised GMII frame generator for the MAC clock domain. It replays a frame stored in an internal byte buffer as preamble, SFD, payload, optional CRC32 and inter-packet gap.
- Supports multi-frame bursts, continuous mode, graceful stop, short-frame padding and fault injection (bad FCS, gmii_er).
- Drives the RX side of TriSpeedEthernetMAC in benches and in loopback self-test builds.

Parameters:
- MAX_FRAME_LEN, 1536, buffer depth in bytes; also the upper clamp on frame_len.
- ADDR_BITS, 11, buffer address width; must satisfy 2^ADDR_BITS >= MAX_FRAME_LEN.
- PREAMBLE_LEN, 7, number of 8'h55 bytes sent before the SFD.
- MIN_IPG, 12, lower clamp on the idle gap between frames, in cycles.

Ports:
- mac_clk  in  1  GMII-rate clock.
- mac_rst_n  in  1  synchronous, active-low reset.
- buf_wr_en  in  1  write one byte into the frame buffer.
- buf_wr_addr  in  ADDR_BITS  buffer write address.
- buf_wr_data  in  8  buffer write data.
- start  in  1  one-cycle pulse; begins a burst.
- stop  in  1  one-cycle pulse; ends the burst after the current frame.
- frame_len  in  ADDR_BITS+1  payload bytes per frame, excluding FCS.
- frame_count  in  16  frames per burst; 0 means continuous.
- ipg  in  8  idle cycles between frames.
- crc_en  in  1  append the computed FCS.
- pad_en  in  1  zero-pad payloads shorter than 60 bytes up to 60.
- crc_corrupt  in  1  invert the last FCS byte.
- err_en  in  1  enable gmii_er injection.
- err_byte  in  ADDR_BITS  payload index at which gmii_er is asserted.
- gmii_dvalid  out  1  always 1 outside reset.
- gmii_en  out  1  GMII TX_EN-equivalent.
- gmii_er  out  1  GMII error.
- gmii_data  out  8  GMII data.
- busy  out  1  high from the cycle after start is accepted until burst end.
- done  out  1  one-cycle pulse at burst end.
- frames_sent  out  16  frames completed in the current or last burst.

Behaviour:
- Reset values: gmii_dvalid=0, gmii_en=0, gmii_er=0, gmii_data=0, busy=0, done=0, frames_sent=0, state IDLE.
- Reset mid-frame: the bus goes idle on the next edge and the frame is truncated. Buffer contents are retained; the RAM has no reset.
- Buffer: single-port write, synchronous read with 1-cycle latency. The implementation prefetches so payload bytes leave back-to-back with no bubbles.
- Writes are dropped while busy=1.
- State machine: IDLE -> PREAMBLE -> SFD -> PAYLOAD -> (PAD) -> (CRC) -> IPG -> PREAMBLE or IDLE.
- IDLE: start accepted only when frame_len != 0. At acceptance, frame_len (clamped to MAX_FRAME_LEN), frame_count, ipg (clamped to MIN_IPG), crc_en, pad_en, crc_corrupt and err_* are latched; frames_sent is cleared. start during busy is ignored.
- Cycle timing: start sampled at edge N. gmii_en=1 with data 8'h55 for cycles N+1 .. N+PREAMBLE_LEN. 8'hD5 at N+PREAMBLE_LEN+1. Payload byte k at N+PREAMBLE_LEN+2+k.
- PAD: entered when pad_en=1 and frame_len<60; emits 8'h00 bytes until 60 bytes total have been sent.
- CRC: Ethernet CRC32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF, final XOR) over payload plus pad. Sent as 4 bytes, least-significant byte first. crc_corrupt XORs the 4th byte with 8'hFF.
- gmii_er is 1 only during the cycle carrying payload index err_byte, when err_en=1 and err_byte < frame_len.
- IPG: gmii_en=0, data=0 for exactly the latched ipg cycles. frames_sent increments on the first IPG cycle.
- Burst end: after IPG, if frames_sent==frame_count (nonzero) or a stop is pending, return to IDLE and pulse done in the same cycle busy falls. Otherwise start the next frame.
- stop is recorded when seen in any non-IDLE state; the current frame always completes, including FCS and IPG.
- stop and start in the same cycle while IDLE: start wins, stop is discarded.
- frame_count=0: runs until stop. frames_sent saturates at 16'hFFFF.

Decomposition:
- Package gmii_gen_pkg: state enum (logic[2:0]), PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, MIN_PADDED_LEN=60, CRC32 polynomial, init and residue constants.
- Sub-module eth_crc32_byte: combinational-next / registered, byte-serial CRC32 with clear, update and current value. It is reused by future RX checker blocks.

Test Plan:
- Load ASCII "123456789", frame_len=9, crc_en=1, pad_en=0, count=1, ipg=12 -> 7x55, D5, 31..39, then 26 39 F4 CB, 12 idle cycles, done pulse, frames_sent=1.
- 110-byte buffer, count=3, ipg=12, crc_en=0 -> three frames of 118 en-cycles each, exactly 12 idle cycles between them, done after the third, busy low on the same cycle.
- frame_len=20, pad_en=1, crc_en=1 -> 20 payload bytes + 40 zeros + 4 FCS bytes (64 en-cycles after SFD); FCS matches a software CRC over the 60 bytes.
- count=0, stop pulsed in the middle of frame 5's payload -> frame 5 completes with FCS and IPG, then IDLE, frames_sent=5, no sixth preamble.
- crc_corrupt=1, err_en=1, err_byte=3 -> gmii_er high only on payload byte 3; last FCS byte equals the golden byte XOR 8'hFF.
- mac_rst_n low during payload byte 40 -> gmii_en=0 on the next edge, busy=0, frames_sent=0. A fresh start afterwards replays the unchanged buffer correctly.

Source files
------------

// File: rtl/gmii_gen_pkg.sv
// Shared types and constants for the GMII frame generator and its CRC helper.
package gmii_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFD,
        ST_PAYLOAD,
        ST_PAD,
        ST_CRC,
        ST_IPG
    } gen_state_e;

    localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
    localparam logic [7:0]  SFD_BYTE        = 8'hD5;
    localparam int          MIN_PADDED_LEN  = 60;

    // Ethernet CRC32: normal polynomial, its bit-reversed form used by the
    // LSB-first engine, init value and the good-frame residue of the register.
    localparam logic [31:0] CRC32_POLY      = 32'h04C11DB7;
    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

    // One byte through the reflected CRC32, bit 0 of the byte first.
    function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c[0] ^ data[i]) ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_crc32_byte.sv
// Byte-serial Ethernet CRC32 register. crc is the raw (non-inverted) state;
// the FCS on the wire is ~crc, least-significant byte first.
module eth_crc32_byte
    import gmii_gen_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        upd,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    logic [31:0] crc_next;

    // Next value with the incoming byte folded in.
    always_comb crc_next = crc32_step(crc, data);

    // Clear wins over update so a new frame always starts from the init value.
    always_ff @(posedge clk) begin
        if (!rst_n)     crc <= CRC32_INIT;
        else if (clr)   crc <= CRC32_INIT;
        else if (upd)   crc <= crc_next;
    end

endmodule

// File: rtl/gmii_traffic_gen.sv
// GMII frame generator: replays the byte buffer as preamble/SFD/payload/
// pad/FCS/IPG, with bursts, continuous mode, graceful stop and fault injection.
// All GMII outputs are registered from the next-state decode, so the state
// register always describes the byte currently on the bus.
module gmii_traffic_gen
    import gmii_gen_pkg::*;
#(
    parameter int MAX_FRAME_LEN = 1536,
    parameter int ADDR_BITS     = 11,
    parameter int PREAMBLE_LEN  = 7,
    parameter int MIN_IPG       = 12
) (
    input  logic                 mac_clk,
    input  logic                 mac_rst_n,
    input  logic                 buf_wr_en,
    input  logic [ADDR_BITS-1:0] buf_wr_addr,
    input  logic [7:0]           buf_wr_data,
    input  logic                 start,
    input  logic                 stop,
    input  logic [ADDR_BITS:0]   frame_len,
    input  logic [15:0]          frame_count,
    input  logic [7:0]           ipg,
    input  logic                 crc_en,
    input  logic                 pad_en,
    input  logic                 crc_corrupt,
    input  logic                 err_en,
    input  logic [ADDR_BITS-1:0] err_byte,
    output logic                 gmii_dvalid,
    output logic                 gmii_en,
    output logic                 gmii_er,
    output logic [7:0]           gmii_data,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          frames_sent
);

    localparam int LEN_W = ADDR_BITS + 1;
    localparam int CNT_W = (LEN_W > 8) ? LEN_W : 8;
    localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(MAX_FRAME_LEN);
    localparam logic [LEN_W-1:0] PAD_LEN   = LEN_W'(MIN_PADDED_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PREAMBLE_LEN - 1);
    localparam logic [CNT_W-1:0] PAD_LAST  = CNT_W'(MIN_PADDED_LEN - 1);
    localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(3);
    localparam logic [7:0]       IPG_MIN   = 8'(MIN_IPG);

    gen_state_e state, nxt_state;
    logic [CNT_W-1:0] cnt, nxt_cnt;
    logic             nxt_en, nxt_er, nxt_done, frame_inc, accept, stop_pend;
    logic [7:0]       nxt_data;

    // Burst parameters captured at start acceptance.
    logic [LEN_W-1:0]     len_l;
    logic [15:0]          count_l;
    logic [7:0]           ipg_l;
    logic                 crc_l, pad_l, corrupt_l, err_en_l;
    logic [ADDR_BITS-1:0] err_byte_l;

    logic [7:0]           mem [MAX_FRAME_LEN];
    logic [7:0]           ram_q;
    logic [ADDR_BITS-1:0] rd_addr;
    logic [31:0]          crc, fcs;
    logic [CNT_W-1:0]     len_c, ipg_c, err_c;
    logic                 short_frame, err_ok;

    assign accept      = (state == ST_IDLE) && start && (frame_len != '0);
    assign len_c       = CNT_W'(len_l);
    assign ipg_c       = CNT_W'(ipg_l);
    assign err_c       = CNT_W'(err_byte_l);
    assign err_ok      = err_en_l && ({1'b0, err_byte_l} < len_l);
    assign short_frame = pad_l && (len_l < PAD_LEN);
    assign fcs         = ~crc;

    // Buffer: writes only while idle; read runs two bytes ahead of the bus so
    // ram_q already holds the next payload byte when it is needed.
    always_ff @(posedge mac_clk) begin
        if (buf_wr_en && !busy && ({1'b0, buf_wr_addr} < MAX_LEN))
            mem[buf_wr_addr] <= buf_wr_data;
        ram_q <= ({1'b0, rd_addr} < MAX_LEN) ? mem[rd_addr] : 8'h00;
    end

    // Prefetch address: byte needed two cycles from now.
    always_comb begin
        rd_addr = '0;
        case (state)
            ST_SFD:     rd_addr = ADDR_BITS'(1);
            ST_PAYLOAD: rd_addr = ADDR_BITS'(cnt + CNT_W'(2));
            default:    rd_addr = '0;
        endcase
    end

    // Next-state and next-bus-byte decode.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_en    = 1'b0;
        nxt_data  = 8'h00;
        nxt_done  = 1'b0;
        frame_inc = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    nxt_state = ST_PREAMBLE;
                    nxt_cnt   = '0;
                    nxt_en    = 1'b1;
                    nxt_data  = PREAMBLE_BYTE;
                end
            end
            ST_PREAMBLE: begin
                nxt_en = 1'b1;
                if (cnt == PRE_LAST) begin
                    nxt_state = ST_SFD;
                    nxt_data  = SFD_BYTE;
                end else begin
                    nxt_cnt  = cnt + CNT_ONE;
                    nxt_data = PREAMBLE_BYTE;
                end
            end
            ST_SFD: begin
                nxt_state = ST_PAYLOAD;
                nxt_cnt   = '0;
                nxt_en    = 1'b1;
                nxt_data  = ram_q;
            end
            ST_PAYLOAD: begin
                if (cnt == len_c - CNT_ONE) begin
                    if (short_frame) begin
                        nxt_state = ST_PAD;
                        nxt_cnt   = len_c;
                        nxt_en    = 1'b1;
                    end else if (crc_l) begin
                        nxt_state = ST_CRC;
                        nxt_cnt   = '0;
                        nxt_en    = 1'b1;
                        nxt_data  = fcs[7:0];
                    end else begin
                        nxt_state = ST_IPG;
                        nxt_cnt   = '0;
                        frame_inc = 1'b1;
                    end
                end else begin
                    nxt_cnt  = cnt + CNT_ONE;
                    nxt_en   = 1'b1;
                    nxt_data = ram_q;
                end
            end
            ST_PAD: begin
                if (cnt == PAD_LAST) begin
                    if (crc_l) begin
                        nxt_state = ST_CRC;
                        nxt_cnt   = '0;
                        nxt_en    = 1'b1;
                        nxt_data  = fcs[7:0];
                    end else begin
                        nxt_state = ST_IPG;
                        nxt_cnt   = '0;
                        frame_inc = 1'b1;
                    end
                end else begin
                    nxt_cnt = cnt + CNT_ONE;
                    nxt_en  = 1'b1;
                end
            end
            ST_CRC: begin
                if (cnt == CRC_LAST) begin
                    nxt_state = ST_IPG;
                    nxt_cnt   = '0;
                    frame_inc = 1'b1;
                end else begin
                    nxt_cnt  = cnt + CNT_ONE;
                    nxt_en   = 1'b1;
                    nxt_data = fcs[{nxt_cnt[1:0], 3'b000} +: 8];
                    if (nxt_cnt == CRC_LAST && corrupt_l)
                        nxt_data = nxt_data ^ 8'hFF;
                end
            end
            ST_IPG: begin
                if (cnt == ipg_c - CNT_ONE) begin
                    // frames_sent already counts the frame whose gap ends here
                    if (stop_pend || stop || (count_l != '0 && frames_sent == count_l)) begin
                        nxt_state = ST_IDLE;
                        nxt_done  = 1'b1;
                    end else begin
                        nxt_state = ST_PREAMBLE;
                        nxt_cnt   = '0;
                        nxt_en    = 1'b1;
                        nxt_data  = PREAMBLE_BYTE;
                    end
                end else begin
                    nxt_cnt = cnt + CNT_ONE;
                end
            end
            default: nxt_state = ST_IDLE;
        endcase
        nxt_er = (nxt_state == ST_PAYLOAD) && err_ok && (nxt_cnt == err_c);
    end

    // FCS covers exactly the bytes going out as payload or pad.
    eth_crc32_byte u_crc (
        .clk   (mac_clk),
        .rst_n (mac_rst_n),
        .clr   (nxt_state == ST_PREAMBLE),
        .upd   ((nxt_state == ST_PAYLOAD) || (nxt_state == ST_PAD)),
        .data  (nxt_data),
        .crc   (crc)
    );

    // State, registered bus outputs, burst bookkeeping and parameter capture.
    always_ff @(posedge mac_clk) begin
        if (!mac_rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            gmii_dvalid <= 1'b0;
            gmii_en     <= 1'b0;
            gmii_er     <= 1'b0;
            gmii_data   <= 8'h00;
            busy        <= 1'b0;
            done        <= 1'b0;
            frames_sent <= '0;
            stop_pend   <= 1'b0;
            len_l       <= '0;
            count_l     <= '0;
            ipg_l       <= IPG_MIN;
            crc_l       <= 1'b0;
            pad_l       <= 1'b0;
            corrupt_l   <= 1'b0;
            err_en_l    <= 1'b0;
            err_byte_l  <= '0;
        end else begin
            state       <= nxt_state;
            cnt         <= nxt_cnt;
            gmii_dvalid <= 1'b1;
            gmii_en     <= nxt_en;
            gmii_er     <= nxt_er;
            gmii_data   <= nxt_data;
            busy        <= (nxt_state != ST_IDLE);
            done        <= nxt_done;
            if (accept) begin
                len_l       <= (frame_len > MAX_LEN) ? MAX_LEN : frame_len;
                count_l     <= frame_count;
                ipg_l       <= (ipg < IPG_MIN) ? IPG_MIN : ipg;
                crc_l       <= crc_en;
                pad_l       <= pad_en;
                corrupt_l   <= crc_corrupt;
                err_en_l    <= err_en;
                err_byte_l  <= err_byte;
                frames_sent <= '0;
                stop_pend   <= 1'b0;
            end else begin
                if (frame_inc && frames_sent != 16'hFFFF)
                    frames_sent <= frames_sent + 16'd1;
                if (nxt_state == ST_IDLE)
                    stop_pend <= 1'b0;
                else if (stop && state != ST_IDLE)
                    stop_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gmii_traffic_gen.sv
// Bench for gmii_traffic_gen: a frame-level model builds the expected byte
// trace of one frame slot (frame + gap) and the burst is checked cycle by cycle.
module tb_gmii_traffic_gen;

    localparam int MAX_FRAME_LEN = 1536;
    localparam int ADDR_BITS     = 11;
    localparam int PREAMBLE_LEN  = 7;
    localparam int MIN_IPG       = 12;

    logic        mac_clk = 1'b0;
    logic        mac_rst_n = 1'b0;
    logic        buf_wr_en = 1'b0;
    logic [10:0] buf_wr_addr = '0;
    logic [7:0]  buf_wr_data = '0;
    logic        start = 1'b0, stop = 1'b0;
    logic [11:0] frame_len = '0;
    logic [15:0] frame_count = '0;
    logic [7:0]  ipg = '0;
    logic        crc_en = 1'b0, pad_en = 1'b0, crc_corrupt = 1'b0, err_en = 1'b0;
    logic [10:0] err_byte = '0;
    logic        gmii_dvalid, gmii_en, gmii_er, busy, done;
    logic [7:0]  gmii_data;
    logic [15:0] frames_sent;

    always #5 mac_clk = ~mac_clk;

    gmii_traffic_gen #(
        .MAX_FRAME_LEN (MAX_FRAME_LEN),
        .ADDR_BITS     (ADDR_BITS),
        .PREAMBLE_LEN  (PREAMBLE_LEN),
        .MIN_IPG       (MIN_IPG)
    ) dut (
        .mac_clk     (mac_clk),
        .mac_rst_n   (mac_rst_n),
        .buf_wr_en   (buf_wr_en),
        .buf_wr_addr (buf_wr_addr),
        .buf_wr_data (buf_wr_data),
        .start       (start),
        .stop        (stop),
        .frame_len   (frame_len),
        .frame_count (frame_count),
        .ipg         (ipg),
        .crc_en      (crc_en),
        .pad_en      (pad_en),
        .crc_corrupt (crc_corrupt),
        .err_en      (err_en),
        .err_byte    (err_byte),
        .gmii_dvalid (gmii_dvalid),
        .gmii_en     (gmii_en),
        .gmii_er     (gmii_er),
        .gmii_data   (gmii_data),
        .busy        (busy),
        .done        (done),
        .frames_sent (frames_sent)
    );

    int          n_chk = 0;
    int          n_fail = 0;
    logic [7:0]  ref_mem [MAX_FRAME_LEN];
    logic [9:0]  tmpl [$];   // {en, er, data} for each cycle of one frame slot

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_crc(input logic [7:0] b [$]);
        logic [31:0] r;
        r = 32'hFFFFFFFF;
        foreach (b[i]) begin
            r = r ^ {24'h0, b[i]};
            repeat (8) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return ~r;
    endfunction

    task automatic build_frame(input int len, input int ipg_eff, input bit c, input bit p,
                               input bit cor, input bit ee, input int eb);
        logic [7:0]  body [$];
        logic [31:0] f;
        tmpl.delete();
        for (int i = 0; i < PREAMBLE_LEN; i++) tmpl.push_back({2'b10, 8'h55});
        tmpl.push_back({2'b10, 8'hD5});
        for (int k = 0; k < len; k++) begin
            body.push_back(ref_mem[k]);
            tmpl.push_back({1'b1, (ee && eb == k), ref_mem[k]});
        end
        if (p) while (body.size() < 60) begin
            body.push_back(8'h00);
            tmpl.push_back({2'b10, 8'h00});
        end
        if (c) begin
            f = ref_crc(body);
            for (int i = 0; i < 4; i++)
                tmpl.push_back({2'b10, f[8*i +: 8] ^ ((cor && i == 3) ? 8'hFF : 8'h00)});
        end
        for (int i = 0; i < ipg_eff; i++) tmpl.push_back(10'h000);
    endtask

    task automatic wr_byte(input int a, input logic [7:0] d);
        @(negedge mac_clk);
        buf_wr_en   = 1'b1;
        buf_wr_addr = 11'(a);
        buf_wr_data = d;
        ref_mem[a]  = d;
    endtask

    task automatic wr_done();
        @(negedge mac_clk);
        buf_wr_en = 1'b0;
    endtask

    function automatic logic [31:0] observed();
        return {3'b000, gmii_dvalid, frames_sent, busy, done, gmii_en, gmii_er, gmii_data};
    endfunction

    // Start a burst and follow it to one cycle past done. stop_at/rst_at are
    // cycle offsets from the first preamble cycle (-1 = never).
    task automatic run_burst(input string tag, input int len, input int cnt, input int ipg_v,
                             input bit c, input bit p, input bit cor, input bit ee, input int eb,
                             input int stop_at, input int rst_at);
        int len_eff, ipg_eff, slot, nfr, total, fr, off, fs;
        logic [31:0] exp_w;
        len_eff = (len > MAX_FRAME_LEN) ? MAX_FRAME_LEN : len;
        ipg_eff = (ipg_v < MIN_IPG) ? MIN_IPG : ipg_v;
        build_frame(len_eff, ipg_eff, c, p, cor, ee, eb);
        slot = tmpl.size();
        if (cnt == 0) nfr = stop_at / slot + 1;
        else begin
            nfr = cnt;
            if (stop_at >= 0 && stop_at / slot + 1 < nfr) nfr = stop_at / slot + 1;
        end
        total = nfr * slot;

        @(negedge mac_clk);
        frame_len   = 12'(len);
        frame_count = 16'(cnt);
        ipg         = 8'(ipg_v);
        crc_en      = c;
        pad_en      = p;
        crc_corrupt = cor;
        err_en      = ee;
        err_byte    = 11'(eb);
        start       = 1'b1;
        stop        = 1'($urandom_range(0, 1));   // start must win over a coincident stop

        for (int t = 0; t <= total + 1; t++) begin
            @(negedge mac_clk);
            start     = 1'b0;
            stop      = 1'b0;
            buf_wr_en = 1'b0;
            if (t < total) begin
                fr    = t / slot;
                off   = t % slot;
                fs    = fr + ((off >= slot - ipg_eff) ? 1 : 0);
                exp_w = {3'b000, 1'b1, 16'(fs), 1'b1, 1'b0, tmpl[off]};
            end else begin
                exp_w = {3'b000, 1'b1, 16'(nfr), 1'b0, (t == total), 10'h000};
            end
            chk($sformatf("%s t=%0d", tag, t), observed(), exp_w);
            if (t == rst_at) begin
                mac_rst_n = 1'b0;
                @(negedge mac_clk);
                chk($sformatf("%s reset_idle", tag), observed(), 32'h0);
                mac_rst_n = 1'b1;
                return;
            end
            if (t == stop_at) stop = 1'b1;
            if (t == 3) begin
                start     = 1'b1;              // must be ignored while busy
                frame_len = 12'(len ^ 1);
            end
            if (t < total && $urandom_range(0, 3) == 0) begin
                buf_wr_en   = 1'b1;            // must be dropped while busy
                buf_wr_addr = 11'($urandom_range(0, 199));
                buf_wr_data = 8'($urandom);
            end
        end
    endtask

    initial begin
        int len, cnt, ig, eb, sa;
        bit c, p, cor, ee;
        string s;

        repeat (3) @(negedge mac_clk);
        chk("reset_state", observed(), 32'h0);
        mac_rst_n = 1'b1;

        for (int a = 0; a < MAX_FRAME_LEN; a++) wr_byte(a, 8'($urandom));
        wr_done();

        s = "123456789";
        for (int i = 0; i < 9; i++) wr_byte(i, s[i]);
        wr_done();
        run_burst("crc9", 9, 1, 12, 1, 0, 0, 0, 0, -1, -1);

        for (int a = 0; a < 110; a++) wr_byte(a, 8'($urandom));
        wr_done();
        run_burst("burst3", 110, 3, 12, 0, 0, 0, 0, 0, -1, -1);
        run_burst("pad20", 20, 1, 12, 1, 1, 0, 0, 0, -1, -1);
        // slot = 8 + 100 + 4 + 12 = 124; stop lands mid-payload of frame 5
        run_burst("stop5", 100, 0, 12, 1, 0, 0, 0, 0, 4 * 124 + 58, -1);
        run_burst("err3", 64, 1, 15, 1, 0, 1, 1, 3, -1, -1);
        run_burst("rst40", 100, 1, 12, 1, 0, 0, 0, 0, -1, 48);
        run_burst("after_rst", 100, 2, 12, 1, 0, 0, 0, 0, -1, -1);
        run_burst("clamp", 2000, 1, 5, 1, 0, 0, 1, 1535, -1, -1);

        @(negedge mac_clk);
        frame_len = '0;
        start     = 1'b1;
        @(negedge mac_clk);
        start = 1'b0;
        chk("zero_len_start", {busy, gmii_en}, 32'h0);

        for (int it = 0; it < 8; it++) begin
            len = $urandom_range(1, 200);
            cnt = $urandom_range(0, 3);
            ig  = $urandom_range(0, 20);
            c   = 1'($urandom_range(0, 1));
            p   = 1'($urandom_range(0, 1));
            cor = 1'($urandom_range(0, 1));
            ee  = 1'($urandom_range(0, 1));
            eb  = $urandom_range(0, len + 2);
            sa  = -1;
            if (cnt == 0 || $urandom_range(0, 1) == 1)
                sa = $urandom_range(0, 2 * (len + 8) + 20);
            run_burst($sformatf("rand%0d", it), len, cnt, ig, c, p, cor, ee, eb, sa, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
